tree_path_decoder: RTL and testbench
====================================

// Module: tree_path_decoder
// PURPOSE
//  Streaming message-tree decoder: consumes field identifiers plus nesting ops, tracks the current
//  message path on a stack, and resolves each (path, id) against a runtime-programmable node table.
//  Generalises the fixed 2-level dependency ROM to MAX_DEPTH levels x NUM_NODES entries.
//  Sits between the wire-format tag parser (upstream) and the field handlers (downstream).
// PARAMETERS
//  ID_W      5   identifier (field tag) width
//  MAX_DEPTH 4   max nesting depth of the path stack
//  NUM_NODES 8   node table entries
//  DATA_W    8   node_data payload width (msg / var type)
// PORTS
//  clk         in   1                        clock; sole clock domain
//  rst         in   1                        synchronous reset, active-high
//  cfg_we      in   1                        write node entry cfg_addr
//  cfg_clr     in   1                        invalidate all entries (wins over cfg_we)
//  cfg_addr    in   $clog2(NUM_NODES)        entry index
//  cfg_depth   in   $clog2(MAX_DEPTH+1)      path length incl. own id (1..MAX_DEPTH)
//  cfg_path    in   MAX_DEPTH*ID_W           level k at [k*ID_W +: ID_W], level 0 = root
//  cfg_data    in   DATA_W                   node_data
//  s_valid     in   1                        input beat valid
//  s_ready     out  1                        input beat accepted when s_valid&s_ready
//  s_op        in   2                        00 FIELD, 01 PUSH, 10 POP, 11 CLEAR
//  s_id        in   ID_W                     identifier (ignored for POP/CLEAR)
//  m_valid     out  1                        result valid
//  m_ready     in   1                        result consumed when m_valid&m_ready
//  m_hit       out  1                        key matched a valid entry
//  m_node_idx  out  $clog2(NUM_NODES)        matching entry (0 on miss)
//  m_data      out  DATA_W                   entry node_data (0 on miss)
//  m_depth     out  $clog2(MAX_DEPTH+1)      stack depth after the op
//  m_err       out  2                        00 none, 01 overflow, 10 underflow
// BEHAVIOUR
//  Reset: depth=0, stack=0, all entries invalid, pipeline empty; m_valid=0, m_hit=0, m_node_idx=0,
//   m_data=0, m_depth=0, m_err=0; s_ready=1 in the cycle after rst deasserts. rst mid-stream drops
//   all in-flight beats.
//  Key at accept: key_path = stack[0..depth-1] ++ s_id, key_depth = depth+1.
//  FIELD: lookup key; stack unchanged. If depth==MAX_DEPTH: no lookup, m_hit=0, m_err=01.
//  PUSH: lookup key; then push s_id (depth+1). If depth==MAX_DEPTH: stack unchanged, m_hit=0, m_err=01.
//  POP: no lookup, m_hit=0; depth-1. If depth==0: unchanged, m_err=10.
//  CLEAR: no lookup, m_hit=0; depth<=0, m_err=00.
//  Stack/depth update at the accept edge; back-to-back beats see the updated stack.
//  Match: entry valid && entry.depth==key_depth && path levels 0..key_depth-1 equal; levels
//   >= key_depth ignored. Multiple matches: lowest index wins.
//  Pipeline: S1 registers key/op/err at accept; S2 registers compare result = output regs.
//   Latency 2 cycles accept->m_valid; throughput 1 beat/cycle with m_ready=1.
//  Stall: S2 holds while m_valid&&!m_ready; S1 advances iff S2 empty or draining;
//   s_ready = !S1_valid || S1_advances. Outputs stable while m_valid&&!m_ready.
//  Config: write at edge t is visible to compares in cycle t+1 onwards; a held S2 result is not
//   re-evaluated. cfg_clr and cfg_we same cycle: clear wins. cfg_depth 0 or >MAX_DEPTH: entry
//   written invalid.
// STRUCTURE
//  tree_pkg: op_t enum, err_t enum, node_entry_t struct {valid, depth, path, data}, tree_key_t.
//  Sub-module tree_node_cam: entry registers + write port + parallel compare + priority encoder
//   (combinational match out, registered by parent S2).
//  Parent: stack + depth counter, S1/S2 pipeline, handshake.
// TESTING (ID_W=5, MAX_DEPTH=4, NUM_NODES=8)
//  cfg e0={d1,[1],0x00}, e1={d2,[1,4],0x01}; PUSH 1, FIELD 4 -> hit idx0 data0 depth1; hit idx1 data1 depth1
//  FIELD 7 at depth1 -> m_hit=0, idx0, data0; POP, POP -> depth0 err00, then depth0 err10
//  4x PUSH 3 then PUSH 3, FIELD 2 -> depth4 err00 x4; then err01 depth4 twice, stack intact
//  e2 and e5 both match [1,4] -> idx2; cfg_clr+cfg_we same cycle -> all miss
//  m_ready low 5 cycles with s_valid=1 -> s_ready drops after 2 beats queued, no loss/dup, order kept
//  rst asserted with 2 beats in flight -> m_valid=0 next cycle, depth0, next FIELD 1 misses

Source files
------------

// File: rtl/tree_pkg.sv
// Shared types for the message-tree path decoder.
package tree_pkg;

    // Default geometry; struct field widths below follow these values.
    localparam int unsigned TREE_ID_W      = 5;
    localparam int unsigned TREE_MAX_DEPTH = 4;
    localparam int unsigned TREE_NUM_NODES = 8;
    localparam int unsigned TREE_DATA_W    = 8;
    localparam int unsigned TREE_IDX_W     = $clog2(TREE_NUM_NODES);
    localparam int unsigned TREE_DEPTH_W   = $clog2(TREE_MAX_DEPTH + 1);
    localparam int unsigned TREE_PATH_W    = TREE_MAX_DEPTH * TREE_ID_W;

    typedef enum logic [1:0] {
        OpField = 2'b00,
        OpPush  = 2'b01,
        OpPop   = 2'b10,
        OpClear = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ErrNone      = 2'b00,
        ErrOverflow  = 2'b01,
        ErrUnderflow = 2'b10
    } err_t;

    typedef struct packed {
        logic                    valid;
        logic [TREE_DEPTH_W-1:0] depth;
        logic [TREE_PATH_W-1:0]  path;
        logic [TREE_DATA_W-1:0]  data;
    } node_entry_t;

    typedef struct packed {
        logic [TREE_DEPTH_W-1:0] depth;
        logic [TREE_PATH_W-1:0]  path;
    } tree_key_t;

endpackage

// File: rtl/tree_node_cam.sv
// Node table: programmable entries, parallel path compare, lowest-index-wins priority encode.
// The match outputs are combinational; the parent registers them.
module tree_node_cam
    import tree_pkg::*;
#(
    parameter int unsigned ID_W      = TREE_ID_W,
    parameter int unsigned MAX_DEPTH = TREE_MAX_DEPTH,
    parameter int unsigned NUM_NODES = TREE_NUM_NODES,
    parameter int unsigned DATA_W    = TREE_DATA_W,
    localparam int unsigned IDX_W    = $clog2(NUM_NODES),
    localparam int unsigned DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we_i,
    input  logic                      cfg_clr_i,
    input  logic [IDX_W-1:0]          cfg_addr_i,
    input  logic [DEPTH_W-1:0]        cfg_depth_i,
    input  logic [MAX_DEPTH*ID_W-1:0] cfg_path_i,
    input  logic [DATA_W-1:0]         cfg_data_i,
    input  tree_key_t                 key_i,
    output logic                      hit_o,
    output logic [IDX_W-1:0]          idx_o,
    output logic [DATA_W-1:0]         data_o
);

    node_entry_t          entries_q [NUM_NODES];
    logic                 cfg_depth_ok;
    logic [NUM_NODES-1:0] match;

    // A path length of zero or beyond the stack can never be looked up.
    assign cfg_depth_ok = (cfg_depth_i != '0) && (cfg_depth_i <= DEPTH_W'(MAX_DEPTH));

    // Entry table write port; a clear beats a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst || cfg_clr_i) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                entries_q[i] <= '0;
            end
        end else if (cfg_we_i) begin
            entries_q[cfg_addr_i] <= '{valid: cfg_depth_ok,
                                       depth: cfg_depth_i,
                                       path:  cfg_path_i,
                                       data:  cfg_data_i};
        end
    end

    // Per-entry compare; only the levels covered by the key depth take part.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            match[i] = entries_q[i].valid && (entries_q[i].depth == key_i.depth);
            for (int k = 0; k < MAX_DEPTH; k++) begin
                if ((DEPTH_W'(k) < key_i.depth) &&
                    (entries_q[i].path[k*ID_W +: ID_W] != key_i.path[k*ID_W +: ID_W])) begin
                    match[i] = 1'b0;
                end
            end
        end
    end

    // Priority encode: scan downwards so the lowest matching index is the last write.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        data_o = '0;
        for (int i = NUM_NODES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o  = 1'b1;
                idx_o  = IDX_W'(i);
                data_o = entries_q[i].data;
            end
        end
    end

endmodule

// File: rtl/tree_path_decoder.sv
// Streaming message-tree decoder: path stack, two-stage lookup pipeline, valid/ready handshake.
module tree_path_decoder
    import tree_pkg::*;
#(
    parameter int unsigned ID_W      = TREE_ID_W,
    parameter int unsigned MAX_DEPTH = TREE_MAX_DEPTH,
    parameter int unsigned NUM_NODES = TREE_NUM_NODES,
    parameter int unsigned DATA_W    = TREE_DATA_W,
    localparam int unsigned IDX_W    = $clog2(NUM_NODES),
    localparam int unsigned DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic                      cfg_clr,
    input  logic [IDX_W-1:0]          cfg_addr,
    input  logic [DEPTH_W-1:0]        cfg_depth,
    input  logic [MAX_DEPTH*ID_W-1:0] cfg_path,
    input  logic [DATA_W-1:0]         cfg_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [1:0]                s_op,
    input  logic [ID_W-1:0]           s_id,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_hit,
    output logic [IDX_W-1:0]          m_node_idx,
    output logic [DATA_W-1:0]         m_data,
    output logic [DEPTH_W-1:0]        m_depth,
    output logic [1:0]                m_err
);

    // Path stack and depth counter
    logic [ID_W-1:0]    stack_q [MAX_DEPTH];
    logic [ID_W-1:0]    stack_d [MAX_DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;

    // S1: accepted beat with its lookup key
    logic               s1_valid_q, s1_valid_d;
    tree_key_t          s1_key_q, s1_key_d;
    logic               s1_lookup_q, s1_lookup_d;
    err_t               s1_err_q, s1_err_d;
    logic [DEPTH_W-1:0] s1_depth_q, s1_depth_d;

    // S2: registered result, drives the outputs directly
    logic               s2_valid_q, s2_valid_d;
    logic               s2_hit_q, s2_hit_d;
    logic [IDX_W-1:0]   s2_idx_q, s2_idx_d;
    logic [DATA_W-1:0]  s2_data_q, s2_data_d;
    logic [DEPTH_W-1:0] s2_depth_q, s2_depth_d;
    err_t               s2_err_q, s2_err_d;

    logic               s2_free, accept, at_max, at_zero;
    op_t                op;
    tree_key_t          beat_key;
    logic               beat_lookup;
    err_t               beat_err;
    logic               cam_hit;
    logic [IDX_W-1:0]   cam_idx;
    logic [DATA_W-1:0]  cam_data;

    assign s2_free = !s2_valid_q || m_ready;
    assign s_ready = !s1_valid_q || s2_free;
    assign accept  = s_valid && s_ready;
    assign op      = op_t'(s_op);
    assign at_max  = (depth_q == DEPTH_W'(MAX_DEPTH));
    assign at_zero = (depth_q == '0);

    // Decode the incoming op: build the key from the current stack and work out the stack update.
    always_comb begin
        stack_d        = stack_q;
        depth_d        = depth_q;
        beat_key.depth = depth_q + DEPTH_W'(1);
        beat_key.path  = '0;
        beat_lookup    = 1'b0;
        beat_err       = ErrNone;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (DEPTH_W'(k) < depth_q) begin
                beat_key.path[k*ID_W +: ID_W] = stack_q[k];
            end else if (DEPTH_W'(k) == depth_q) begin
                beat_key.path[k*ID_W +: ID_W] = s_id;
            end
        end
        case (op)
            OpField: begin
                if (at_max) beat_err = ErrOverflow;
                else        beat_lookup = 1'b1;
            end
            OpPush: begin
                if (at_max) begin
                    beat_err = ErrOverflow;
                end else begin
                    beat_lookup = 1'b1;
                    depth_d     = depth_q + DEPTH_W'(1);
                    for (int k = 0; k < MAX_DEPTH; k++) begin
                        if (DEPTH_W'(k) == depth_q) stack_d[k] = s_id;
                    end
                end
            end
            OpPop: begin
                if (at_zero) beat_err = ErrUnderflow;
                else         depth_d = depth_q - DEPTH_W'(1);
            end
            OpClear: depth_d = '0;
            default: ;
        endcase
        if (!accept) begin
            stack_d = stack_q;
            depth_d = depth_q;
        end
    end

    tree_node_cam #(
        .ID_W      (ID_W),
        .MAX_DEPTH (MAX_DEPTH),
        .NUM_NODES (NUM_NODES),
        .DATA_W    (DATA_W)
    ) u_cam (
        .clk         (clk),
        .rst         (rst),
        .cfg_we_i    (cfg_we),
        .cfg_clr_i   (cfg_clr),
        .cfg_addr_i  (cfg_addr),
        .cfg_depth_i (cfg_depth),
        .cfg_path_i  (cfg_path),
        .cfg_data_i  (cfg_data),
        .key_i       (s1_key_q),
        .hit_o       (cam_hit),
        .idx_o       (cam_idx),
        .data_o      (cam_data)
    );

    // Pipeline next state: S2 holds under back-pressure, S1 refills whenever it can hand off.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_key_d    = s1_key_q;
        s1_lookup_d = s1_lookup_q;
        s1_err_d    = s1_err_q;
        s1_depth_d  = s1_depth_q;
        s2_valid_d  = s2_valid_q;
        s2_hit_d    = s2_hit_q;
        s2_idx_d    = s2_idx_q;
        s2_data_d   = s2_data_q;
        s2_depth_d  = s2_depth_q;
        s2_err_d    = s2_err_q;
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_hit_d   = s1_lookup_q && cam_hit;
                s2_idx_d   = (s1_lookup_q && cam_hit) ? cam_idx : '0;
                s2_data_d  = (s1_lookup_q && cam_hit) ? cam_data : '0;
                s2_depth_d = s1_depth_q;
                s2_err_d   = s1_err_q;
            end
        end
        if (s_ready) begin
            s1_valid_d = s_valid;
            if (s_valid) begin
                s1_key_d    = beat_key;
                s1_lookup_d = beat_lookup;
                s1_err_d    = beat_err;
                s1_depth_d  = depth_d;
            end
        end
    end

    // State registers; reset drops every in-flight beat and empties the stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                stack_q[k] <= '0;
            end
            depth_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_key_q    <= '0;
            s1_lookup_q <= 1'b0;
            s1_err_q    <= ErrNone;
            s1_depth_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_hit_q    <= 1'b0;
            s2_idx_q    <= '0;
            s2_data_q   <= '0;
            s2_depth_q  <= '0;
            s2_err_q    <= ErrNone;
        end else begin
            stack_q     <= stack_d;
            depth_q     <= depth_d;
            s1_valid_q  <= s1_valid_d;
            s1_key_q    <= s1_key_d;
            s1_lookup_q <= s1_lookup_d;
            s1_err_q    <= s1_err_d;
            s1_depth_q  <= s1_depth_d;
            s2_valid_q  <= s2_valid_d;
            s2_hit_q    <= s2_hit_d;
            s2_idx_q    <= s2_idx_d;
            s2_data_q   <= s2_data_d;
            s2_depth_q  <= s2_depth_d;
            s2_err_q    <= s2_err_d;
        end
    end

    assign m_valid    = s2_valid_q;
    assign m_hit      = s2_hit_q;
    assign m_node_idx = s2_idx_q;
    assign m_data     = s2_data_q;
    assign m_depth    = s2_depth_q;
    assign m_err      = s2_err_q;

endmodule

// File: tb/tb_tree_path_decoder.sv
// Directed bench for tree_path_decoder with hand-computed expected results.
module tb_tree_path_decoder;

    localparam logic [1:0] OP_FIELD = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [7:0] data;
        logic [2:0] depth;
        logic [1:0] err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we, cfg_clr;
    logic [2:0]  cfg_addr, cfg_depth;
    logic [19:0] cfg_path;
    logic [7:0]  cfg_data;
    logic        s_valid, s_ready;
    logic [1:0]  s_op;
    logic [4:0]  s_id;
    logic        m_valid, m_ready, m_hit;
    logic [2:0]  m_node_idx, m_depth;
    logic [7:0]  m_data;
    logic [1:0]  m_err;

    int   checks   = 0;
    int   failures = 0;
    res_t q[$];

    always #5 clk = ~clk;

    tree_path_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_clr    (cfg_clr),
        .cfg_addr   (cfg_addr),
        .cfg_depth  (cfg_depth),
        .cfg_path   (cfg_path),
        .cfg_data   (cfg_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_op       (s_op),
        .s_id       (s_id),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_hit      (m_hit),
        .m_node_idx (m_node_idx),
        .m_data     (m_data),
        .m_depth    (m_depth),
        .m_err      (m_err)
    );

    // Record every consumed result, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) q.push_back({m_hit, m_node_idx, m_data, m_depth, m_err});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] p(input logic [4:0] l0, input logic [4:0] l1,
                                      input logic [4:0] l2, input logic [4:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic cfg_write(input logic [2:0] addr, input logic [2:0] d,
                             input logic [19:0] path, input logic [7:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_depth = d; cfg_path = path; cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] id);
        int   n  = 0;
        logic ok = 1'b0;
        s_valid = 1'b1; s_op = op; s_id = id;
        do begin
            @(negedge clk); ok = s_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int c = 0;
        while (q.size() < n && c < 20) begin
            @(posedge clk); #1; c++;
        end
        check("drain_count", q.size(), n);
    endtask

    task automatic expect_res(input string tag, input logic hit, input logic [2:0] idx,
                              input logic [7:0] data, input logic [2:0] depth,
                              input logic [1:0] err);
        res_t r;
        check({tag, "_avail"}, 32'(q.size() != 0), 32'd1);
        if (q.size() == 0) return;
        r = q.pop_front();
        check({tag, "_hit"}, 32'(r.hit), 32'(hit));
        check({tag, "_idx"}, 32'(r.idx), 32'(idx));
        check({tag, "_data"}, 32'(r.data), 32'(data));
        check({tag, "_depth"}, 32'(r.depth), 32'(depth));
        check({tag, "_err"}, 32'(r.err), 32'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        logic rdy;
        rst = 1'b1; cfg_we = 1'b0; cfg_clr = 1'b0; cfg_addr = '0; cfg_depth = '0;
        cfg_path = '0; cfg_data = '0; s_valid = 1'b0; s_op = '0; s_id = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_hit", 32'(m_hit), 0);
        check("rst_m_idx", 32'(m_node_idx), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_m_depth", 32'(m_depth), 0);
        check("rst_m_err", 32'(m_err), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 1);
        @(posedge clk); #1;

        // Basic lookups; e0 carries junk in an unused level that must be ignored.
        cfg_write(3'd0, 3'd1, p(5'd1, 5'd9, 5'd0, 5'd0), 8'h00);
        cfg_write(3'd1, 3'd2, p(5'd1, 5'd4, 5'd0, 5'd0), 8'h01);
        send(OP_PUSH, 5'd1);
        send(OP_FIELD, 5'd4);
        send(OP_FIELD, 5'd7);
        send(OP_POP, 5'd0);
        send(OP_POP, 5'd0);
        drain(5);
        expect_res("push1", 1, 3'd0, 8'h00, 3'd1, 2'b00);
        expect_res("field4", 1, 3'd1, 8'h01, 3'd1, 2'b00);
        expect_res("field7", 0, 3'd0, 8'h00, 3'd1, 2'b00);
        expect_res("pop", 0, 3'd0, 8'h00, 3'd0, 2'b00);
        expect_res("pop_under", 0, 3'd0, 8'h00, 3'd0, 2'b10);

        // Fill the stack, overflow twice, then prove the stack survived.
        cfg_write(3'd3, 3'd4, p(5'd3, 5'd3, 5'd3, 5'd3), 8'h33);
        repeat (4) send(OP_PUSH, 5'd3);
        send(OP_PUSH, 5'd3);
        send(OP_FIELD, 5'd2);
        send(OP_POP, 5'd0);
        send(OP_FIELD, 5'd3);
        send(OP_CLEAR, 5'd0);
        drain(9);
        expect_res("push_d1", 0, 3'd0, 8'h00, 3'd1, 2'b00);
        expect_res("push_d2", 0, 3'd0, 8'h00, 3'd2, 2'b00);
        expect_res("push_d3", 0, 3'd0, 8'h00, 3'd3, 2'b00);
        expect_res("push_d4", 1, 3'd3, 8'h33, 3'd4, 2'b00);
        expect_res("push_ovf", 0, 3'd0, 8'h00, 3'd4, 2'b01);
        expect_res("field_ovf", 0, 3'd0, 8'h00, 3'd4, 2'b01);
        expect_res("pop_d3", 0, 3'd0, 8'h00, 3'd3, 2'b00);
        expect_res("stack_intact", 1, 3'd3, 8'h33, 3'd3, 2'b00);
        expect_res("clear", 0, 3'd0, 8'h00, 3'd0, 2'b00);

        // Priority, invalid depths and clear-beats-write.
        cfg_write(3'd2, 3'd2, p(5'd1, 5'd4, 5'd0, 5'd0), 8'h22);
        cfg_write(3'd5, 3'd2, p(5'd1, 5'd4, 5'd0, 5'd0), 8'h55);
        cfg_write(3'd1, 3'd0, p(5'd1, 5'd4, 5'd0, 5'd0), 8'h01);
        send(OP_PUSH, 5'd1);
        send(OP_FIELD, 5'd4);
        cfg_write(3'd1, 3'd5, p(5'd1, 5'd4, 5'd0, 5'd0), 8'h01);
        send(OP_FIELD, 5'd4);
        cfg_clr = 1'b1;
        cfg_write(3'd6, 3'd2, p(5'd1, 5'd4, 5'd0, 5'd0), 8'h66);
        cfg_clr = 1'b0;
        send(OP_FIELD, 5'd4);
        send(OP_CLEAR, 5'd0);
        drain(5);
        expect_res("prio_push1", 1, 3'd0, 8'h00, 3'd1, 2'b00);
        expect_res("prio_low", 1, 3'd2, 8'h22, 3'd1, 2'b00);
        expect_res("depth5_invalid", 1, 3'd2, 8'h22, 3'd1, 2'b00);
        expect_res("clr_wins", 0, 3'd0, 8'h00, 3'd1, 2'b00);
        expect_res("clear2", 0, 3'd0, 8'h00, 3'd0, 2'b00);

        // Back-pressure: only two beats fit while the output is stalled.
        cfg_write(3'd4, 3'd1, p(5'd10, 5'd0, 5'd0, 5'd0), 8'hA0);
        cfg_write(3'd7, 3'd1, p(5'd13, 5'd0, 5'd0, 5'd0), 8'hD0);
        m_ready = 1'b0; s_valid = 1'b1; s_op = OP_FIELD; accepted = 0;
        for (int c = 0; c < 5; c++) begin
            s_id = 5'(10 + accepted);
            @(negedge clk); rdy = s_ready;
            if (rdy) accepted++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("stall_accepted", accepted, 2);
        @(negedge clk);
        check("stall_s_ready", 32'(s_ready), 0);
        check("stall_m_valid", 32'(m_valid), 1);
        check("stall_m_hit", 32'(m_hit), 1);
        check("stall_m_data", 32'(m_data), 32'hA0);
        check("stall_no_output", q.size(), 0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        send(OP_FIELD, 5'd12);
        send(OP_FIELD, 5'd13);
        drain(4);
        expect_res("ord10", 1, 3'd4, 8'hA0, 3'd0, 2'b00);
        expect_res("ord11", 0, 3'd0, 8'h00, 3'd0, 2'b00);
        expect_res("ord12", 0, 3'd0, 8'h00, 3'd0, 2'b00);
        expect_res("ord13", 1, 3'd7, 8'hD0, 3'd0, 2'b00);

        // Reset with two beats in flight.
        cfg_write(3'd0, 3'd1, p(5'd1, 5'd0, 5'd0, 5'd0), 8'h11);
        send(OP_FIELD, 5'd1);
        send(OP_PUSH, 5'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid), 0);
        check("midrst_m_depth", 32'(m_depth), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_dropped", q.size(), 0);
        send(OP_FIELD, 5'd1);
        drain(1);
        expect_res("post_rst_miss", 0, 3'd0, 8'h00, 3'd0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        check("no_extra_results", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
